// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay timer among NREQ requesters.
// Optional RUN-state watchdog compiled in with `define DELAY_ARB_WATCHDOG_EN.
module delay_arbiter #(
  parameter int NREQ        = 4,
  parameter int AMT_W       = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AMT_W-1:0] amt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                  err,
  output logic                  tmr_start,
  output logic [AMT_W-1:0]      tmr_amount,
  input  logic                  tmr_en
);

  localparam int IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("delay_arbiter: NREQ must be 2..8 and TIMEOUT_CYC at least 1");
  end

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, GAP} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] pick;
  logic           any_req;

  // Descending scan so the nearest requester after ptr is written last.
  always_comb begin
    int unsigned    idx;
    logic [IDW-1:0] sel;
    idx     = 0;
    sel     = '0;
    pick    = '0;
    any_req = 1'b0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      idx = (32'(ptr) + i) % NREQ;
      sel = IDW'(idx);
      if (req[sel]) begin
        pick    = sel;
        any_req = 1'b1;
      end
    end
  end

`ifdef DELAY_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IDW'(NREQ - 1);
      done       <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      tmr_start  <= 1'b0;
      tmr_amount <= '0;
`ifdef DELAY_ARB_WATCHDOG_EN
      err        <= 1'b0;
      wd_cnt     <= '0;
`endif
    end else begin
      done <= '0;
`ifdef DELAY_ARB_WATCHDOG_EN
      err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id   <= pick;
            ptr        <= pick;
            tmr_amount <= amt[32'(pick)*AMT_W +: AMT_W];
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          tmr_start <= 1'b1;
          state     <= RUN;
`ifdef DELAY_ARB_WATCHDOG_EN
          wd_cnt    <= '0;
`endif
        end
        RUN: begin
          // Timer terminal pulse takes precedence over a same-cycle withdrawal.
          if (tmr_en) begin
            tmr_start      <= 1'b0;
            done[grant_id] <= 1'b1;
            state          <= DONE;
          end else if (!req[grant_id]) begin
            tmr_start <= 1'b0;
            state     <= GAP;
          end
`ifdef DELAY_ARB_WATCHDOG_EN
          else if (wd_cnt == WDW'(TIMEOUT_CYC - 1)) begin
            tmr_start <= 1'b0;
            err       <= 1'b1;
            state     <= GAP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        DONE: state <= GAP;
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/delay_arbiter.md
# delay_arbiter

Shares the single LED-CPU delay timer among NREQ requesters. Each requester asks for a delay of its own 8-bit amount. The arbiter grants requests round-robin and drives the timer's start/stop and amount inputs. It pulses a per-requester done once the timer's terminal enable fires. It sits between the CPU/peripheral delay requesters and the one timer instance, so no requester drives the timer directly.

## Interface
- NREQ, 4, number of requesters (2..8)
- AMT_W, 8, amount width; matches the timer amount input
- TIMEOUT_CYC, 1023, RUN-state watchdog limit in cycles; used only when the watchdog is compiled in
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  level request per requester; held until that requester's done
- amt  in  NREQ*AMT_W  packed amounts; requester i uses bits [i*AMT_W +: AMT_W]
- done  out  NREQ  one-cycle completion pulse, one-hot
- busy  out  1  high in every state except IDLE
- grant_id  out  clog2(NREQ)  index of the current or last granted requester
- err  out  1  one-cycle watchdog-abort pulse
- tmr_start  out  1  to the timer's startStop input
- tmr_amount  out  AMT_W  to the timer's amount input
- tmr_en  in  1  timer terminal pulse

## Operation
- All outputs are registered.
- Reset values:
  - done=0, busy=0, grant_id=0, err=0, tmr_start=0, tmr_amount=0
  - state=IDLE, round-robin pointer=NREQ-1, so requester 0 has first priority
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from pointer+1, wrapping.
  - Latch grant_id and that requester's amount into tmr_amount; pointer ← grant_id.
  - Go to LOAD.
- LOAD: tmr_start=0 and tmr_amount is stable for one cycle; go to RUN.
- RUN:
  - tmr_start=1 and tmr_amount is held.
  - If tmr_en is sampled high, go to DONE.
  - Else if req[grant_id] is low (withdrawn), go to GAP with no done.
  - If tmr_en and the withdrawal occur in the same cycle, tmr_en wins and the state goes to DONE.
- DONE: done[grant_id]=1 for exactly one cycle, tmr_start=0; go to GAP.
- GAP: tmr_start=0 for one cycle so the timer returns to idle and clears its count; go to IDLE.
- Request handling:
  - Requests that arrive while busy wait; none are lost, since they are level-held.
  - A requester may re-request immediately after its done. Round-robin still grants the other pending requesters first.
- amt=0 is legal. The timer fires at its first counting cycle.
- amt inputs of non-granted requesters may change at any time. The granted amount is frozen at the IDLE→LOAD transition.

## Timing
- Cycle 0 is IDLE sampling req. LOAD follows at cycle 1 and RUN at cycle 2 with tmr_start rising.
- With the shared timer, tmr_en is high at cycle amt+4. DONE follows with done high at cycle amt+5.
- One grant occupies amt+7 cycles from the IDLE sample to the next IDLE. Back-to-back requests are re-granted at the next IDLE cycle.
- rst mid-operation: all outputs return to reset values on the next edge. tmr_start=0 is sufficient to stop the timer. No done pulse is issued.

## Configuration
- DELAY_ARB_WATCHDOG_EN defined:
  - A counter clears on RUN entry and increments every RUN cycle.
  - On reaching TIMEOUT_CYC without tmr_en: pulse err for one cycle, no done, go to GAP.
- Undefined: no counter, err is tied to 0, and RUN waits indefinitely for tmr_en.

## Test plan
- Reset: hold rst for 3 cycles, then req=0 → all outputs 0 and busy=0 indefinitely.
- Single request: req[0]=1 with amt0=3 at cycle 0 → tmr_start rises at cycle 2 and done[0] is high only at cycle 8. The timer has tmr_amount=3.
- Round-robin: req=4'b1111 with all amounts 1, held until each done → grants in order 0,1,2,3,0. No requester is granted twice while another is pending.
- Withdraw: req[2] is granted with amt=50 and dropped 10 cycles into RUN → no done, GAP, then IDLE, and the next pending requester is granted.
- Reset mid-RUN: assert rst during RUN → tmr_start=0, busy=0 and grant_id=0 next cycle, and no done pulse occurs.
- Watchdog (macro defined, TIMEOUT_CYC=20): tmr_en is tied 0 and req[1]=1 → err is high for one cycle 20 cycles after RUN entry, no done, and the arbiter returns to IDLE.
